// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - single-port frame-buffer BRAM arbiter for display, pixel writes and clear
module fb_port_arbiter #(
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int ADDR_W = 17,
  parameter int PIX_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              visible,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [8:0]        wr_x,
  input  logic [7:0]        wr_y,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_drop,
  input  logic              clr_start,
  input  logic [PIX_W-1:0]  clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_din,
  input  logic [PIX_W-1:0]  mem_dout,
  output logic [PIX_W-1:0]  disp_pixel
);

  localparam logic [9:0]        LP_FB_W   = 10'(FB_W);
  localparam logic [9:0]        LP_FB_H   = 10'(FB_H);
  localparam logic [ADDR_W-1:0] LP_FB_W_A = ADDR_W'(FB_W);
  localparam logic [ADDR_W-1:0] LP_LAST   = ADDR_W'(FB_W * FB_H - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_addr;
  logic [PIX_W-1:0]    r_clr_color;
  logic                r_clr_done;
  logic                r_wr_drop;
  logic                r_disp_d;
  logic [PIX_W-1:0]    r_disp_pixel;

  logic [8:0]          w_hx;
  logic [8:0]          w_vy;
  logic                w_disp_slot;
  logic                w_wr_in_range;
  logic [ADDR_W-1:0]   w_disp_addr;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic                w_clr_adv;
  logic                w_wr_oob;

  // Memory pixel coordinates: the display is 2x upscaled in both directions.
  assign w_hx = h_cnt[9:1];
  assign w_vy = v_cnt[9:1];

  assign w_disp_slot = visible && !h_cnt[0] &&
                       ({1'b0, w_hx} < LP_FB_W) && ({1'b0, w_vy} < LP_FB_H);

  assign w_wr_in_range = ({1'b0, wr_x} < LP_FB_W) && ({2'b00, wr_y} < LP_FB_H);

  assign w_disp_addr = ADDR_W'(w_vy) * LP_FB_W_A + ADDR_W'(w_hx);

  // y*320 as a shift-add: y*256 + y*64.
  assign w_wr_addr = (ADDR_W'(wr_y) << 8) + (ADDR_W'(wr_y) << 6) + ADDR_W'(wr_x);

  assign clr_busy   = (r_state == S_CLEAR);
  assign clr_done   = r_clr_done;
  assign wr_drop    = r_wr_drop;
  assign disp_pixel = r_disp_pixel;

  // Clear FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Port mux and next state: display slots always win, clear beats the write port.
  always_comb begin
    w_state_nxt = r_state;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_din     = '0;
    wr_ready    = 1'b0;
    w_clr_adv   = 1'b0;
    w_wr_oob    = 1'b0;
    if (w_disp_slot) begin
      mem_addr = w_disp_addr;
    end else begin
      case (r_state)
        S_CLEAR: begin
          mem_we    = 1'b1;
          mem_addr  = r_clr_addr;
          mem_din   = r_clr_color;
          w_clr_adv = 1'b1;
          if (r_clr_addr == LP_LAST) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          wr_ready = 1'b1;
          if (wr_valid) begin
            if (w_wr_in_range) begin
              mem_we   = 1'b1;
              mem_addr = w_wr_addr;
              mem_din  = wr_data;
            end else begin
              w_wr_oob = 1'b1;
            end
          end
        end
      endcase
    end
    // A clear request is accepted in any idle cycle, after this cycle's write is served.
    if (r_state == S_IDLE && clr_start) begin
      w_state_nxt = S_CLEAR;
    end
  end

  // Clear address counter and latched fill colour.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_addr  <= '0;
      r_clr_color <= '0;
    end else if (r_state == S_IDLE && clr_start) begin
      r_clr_addr  <= '0;
      r_clr_color <= clr_color;
    end else if (w_clr_adv) begin
      r_clr_addr  <= r_clr_addr + 1'b1;
    end
  end

  // One-cycle status pulses: clear finished, write discarded as out of range.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_done <= 1'b0;
      r_wr_drop  <= 1'b0;
    end else begin
      r_clr_done <= w_clr_adv && (r_clr_addr == LP_LAST);
      r_wr_drop  <= w_wr_oob;
    end
  end

  // Display pipeline: capture BRAM data at the end of each odd cycle, blank if the even cycle was not a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp_d     <= 1'b0;
      r_disp_pixel <= '0;
    end else begin
      r_disp_d <= w_disp_slot;
      if (h_cnt[0]) begin
        r_disp_pixel <= r_disp_d ? mem_dout : '0;
      end
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - directed scoreboard bench for fb_port_arbiter
module tb_fb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  h_cnt, v_cnt;
  logic        visible, wr_valid, wr_ready;
  logic [8:0]  wr_x;
  logic [7:0]  wr_y;
  logic [11:0] wr_data, clr_color, mem_din, mem_dout, disp_pixel;
  logic        wr_drop, clr_start, clr_busy, clr_done, mem_we;
  logic [16:0] mem_addr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  fb_port_arbiter dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .visible(visible),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .wr_drop(wr_drop), .clr_start(clr_start),
    .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout), .disp_pixel(disp_pixel)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%0h required=queued_value", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          err_cnt;
    int          done_cnt;
    int          ecnt;
    int          ncyc;
    int          h, v;
    logic        disp;
    logic [31:0] eaddr;

    rst = 1'b1; h_cnt = '0; v_cnt = '0; visible = 1'b0;
    wr_valid = 1'b1; wr_x = 9'd5; wr_y = 8'd2; wr_data = 12'h000;
    clr_start = 1'b0; clr_color = '0; mem_dout = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    push("rst_disp", 0);  pop_cmp(32'(disp_pixel));
    push("rst_busy", 0);  pop_cmp(32'(clr_busy));
    push("rst_drop", 0);  pop_cmp(32'(wr_drop));

    next_cyc();
    visible = 1'b0; wr_valid = 1'b1; wr_x = 9'd5; wr_y = 8'd2; wr_data = 12'hF00;
    h_cnt = 10'd700;
    @(negedge clk);
    push("wr_ready", 1);  pop_cmp(32'(wr_ready));
    push("wr_we", 1);     pop_cmp(32'(mem_we));
    push("wr_addr", 645); pop_cmp(32'(mem_addr));
    push("wr_din", 12'hF00); pop_cmp(32'(mem_din));

    next_cyc();
    visible = 1'b1; v_cnt = 10'd4; h_cnt = 10'd10;
    @(negedge clk);
    push("disp_addr", 645);  pop_cmp(32'(mem_addr));
    push("disp_we", 0);      pop_cmp(32'(mem_we));
    push("disp_ready", 0);   pop_cmp(32'(wr_ready));

    next_cyc();
    h_cnt = 10'd11; mem_dout = 12'hABC;
    @(negedge clk);
    push("odd_ready", 1); pop_cmp(32'(wr_ready));
    push("odd_we", 1);    pop_cmp(32'(mem_we));

    next_cyc();
    h_cnt = 10'd12; mem_dout = 12'h000; wr_valid = 1'b0;
    @(negedge clk);
    push("pix_t2", 12'hABC); pop_cmp(32'(disp_pixel));

    next_cyc();
    h_cnt = 10'd13; mem_dout = 12'h123;
    @(negedge clk);
    push("pix_t3", 12'hABC); pop_cmp(32'(disp_pixel));

    next_cyc();
    h_cnt = 10'd14; mem_dout = 12'h000;
    @(negedge clk);
    push("pix_next", 12'h123); pop_cmp(32'(disp_pixel));

    next_cyc();
    visible = 1'b0; h_cnt = 10'd700;
    next_cyc();
    h_cnt = 10'd701; mem_dout = 12'h777;
    @(negedge clk);
    push("pix_hold", 12'h123); pop_cmp(32'(disp_pixel));
    next_cyc();
    h_cnt = 10'd702; mem_dout = 12'h000;
    @(negedge clk);
    push("pix_blank", 0); pop_cmp(32'(disp_pixel));

    next_cyc();
    wr_valid = 1'b1; wr_x = 9'd320; wr_y = 8'd0; wr_data = 12'h111;
    @(negedge clk);
    push("oob_ready", 1); pop_cmp(32'(wr_ready));
    push("oob_we", 0);    pop_cmp(32'(mem_we));
    next_cyc();
    wr_valid = 1'b0;
    @(negedge clk);
    push("oob_drop", 1); pop_cmp(32'(wr_drop));
    next_cyc();
    @(negedge clk);
    push("drop_pulse", 0); pop_cmp(32'(wr_drop));

    next_cyc();
    wr_valid = 1'b1; wr_x = 9'd319; wr_y = 8'd239; wr_data = 12'h5A5;
    @(negedge clk);
    push("max_we", 1);       pop_cmp(32'(mem_we));
    push("max_addr", 76799); pop_cmp(32'(mem_addr));
    next_cyc();
    wr_x = 9'd0; wr_y = 8'd240;
    @(negedge clk);
    push("y240_we", 0); pop_cmp(32'(mem_we));
    next_cyc();
    wr_valid = 1'b0;
    @(negedge clk);
    push("y240_drop", 1); pop_cmp(32'(wr_drop));

    next_cyc();
    wr_valid = 1'b1; wr_x = 9'd1; wr_y = 8'd0; wr_data = 12'h0F0;
    clr_start = 1'b1; clr_color = 12'h0A5; visible = 1'b0;
    @(negedge clk);
    push("cs_ready", 1);    pop_cmp(32'(wr_ready));
    push("cs_we", 1);       pop_cmp(32'(mem_we));
    push("cs_addr", 1);     pop_cmp(32'(mem_addr));
    push("cs_din", 12'h0F0); pop_cmp(32'(mem_din));
    push("cs_busy", 0);     pop_cmp(32'(clr_busy));

    err_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 76800; i++) begin
      next_cyc();
      clr_start = (i == 100);
      clr_color = (i == 100) ? 12'hFFF : 12'h0A5;
      @(negedge clk);
      if (!(mem_we === 1'b1 && mem_addr === 17'(i) && mem_din === 12'h0A5 &&
            wr_ready === 1'b0 && clr_busy === 1'b1))
        err_cnt++;
      if (clr_done === 1'b1) done_cnt++;
    end
    push("clr_seq_err", 0);     pop_cmp(32'(err_cnt));
    push("clr_early_done", 0);  pop_cmp(32'(done_cnt));

    next_cyc();
    wr_valid = 1'b0; clr_start = 1'b0;
    @(negedge clk);
    push("clr_done", 1);   pop_cmp(32'(clr_done));
    push("clr_idle", 0);   pop_cmp(32'(clr_busy));
    push("clr_end_we", 0); pop_cmp(32'(mem_we));
    next_cyc();
    @(negedge clk);
    push("done_pulse", 0); pop_cmp(32'(clr_done));

    next_cyc();
    clr_start = 1'b1; clr_color = 12'h3C3; visible = 1'b0; h_cnt = 10'd799; v_cnt = 10'd524;
    ecnt = 0; ncyc = 0; err_cnt = 0; h = 0; v = 0;
    while (ecnt < 1000 && ncyc < 5000) begin
      next_cyc();
      clr_start = 1'b0;
      h_cnt = 10'(h); v_cnt = 10'(v);
      visible = (h < 640) && (v < 480);
      @(negedge clk);
      disp = visible && (h % 2 == 0) && ((h / 2) < 320) && ((v / 2) < 240);
      if (disp) begin
        eaddr = 32'((v / 2) * 320 + (h / 2));
        if (!(mem_we === 1'b0 && 32'(mem_addr) === eaddr)) err_cnt++;
      end else begin
        if (!(mem_we === 1'b1 && 32'(mem_addr) === 32'(ecnt) && mem_din === 12'h3C3)) err_cnt++;
        ecnt++;
      end
      ncyc++;
      h++;
      if (h == 800) begin
        h = 0;
        v++;
      end
    end
    push("mix_reach_1000", 1000); pop_cmp(32'(ecnt));
    push("mix_seq_err", 0);       pop_cmp(32'(err_cnt));

    next_cyc();
    rst = 1'b1; visible = 1'b0;
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    push("abort_busy", 0); pop_cmp(32'(clr_busy));
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (clr_done === 1'b1) done_cnt++;
      next_cyc();
      @(negedge clk);
    end
    push("abort_no_done", 0); pop_cmp(32'(done_cnt));

    next_cyc();
    clr_start = 1'b1; clr_color = 12'h00F;
    next_cyc();
    clr_start = 1'b0;
    @(negedge clk);
    push("restart_busy", 1);   pop_cmp(32'(clr_busy));
    push("restart_addr", 0);   pop_cmp(32'(mem_addr));
    push("restart_we", 1);     pop_cmp(32'(mem_we));
    push("restart_din", 12'h00F); pop_cmp(32'(mem_din));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
